alu_dispatcher: RTL



---
 rtl/alu_dispatcher.sv | 102 ++++++++++
 1 files changed

// File: rtl/alu_dispatcher.sv
// Issue-side ALU controller: accepts one operation, holds the ALU inputs for a
// per-class fixed latency, captures the answer and returns it with its tag.
module alu_dispatcher #(
  parameter int LAT_SIMPLE = 2,
  parameter int LAT_MUL    = 6,
  parameter int LAT_DIV    = 34,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_op1,
  input  logic [31:0]      req_op2,
  input  logic [4:0]       req_opcode,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_operator_1,
  output logic [31:0]      alu_operator_2,
  output logic [4:0]       alu_opcode,
  input  logic [31:0]      alu_answer,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int MAX_LAT = (LAT_DIV > LAT_MUL) ?
                           ((LAT_DIV > LAT_SIMPLE) ? LAT_DIV : LAT_SIMPLE) :
                           ((LAT_MUL > LAT_SIMPLE) ? LAT_MUL : LAT_SIMPLE);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [TAG_W-1:0]   tag_lat;

  // Counter preload: capture lands exactly LAT cycles after acceptance.
  function automatic logic [CNT_W-1:0] lat_load(input logic [4:0] op);
    if (op[4:2] == 3'b010)      return CNT_W'(LAT_MUL - 1);
    else if (op[4:2] == 3'b011) return CNT_W'(LAT_DIV - 1);
    else                        return CNT_W'(LAT_SIMPLE - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      busy           <= 1'b0;
      rsp_data       <= '0;
      rsp_tag        <= '0;
      tag_lat        <= '0;
      alu_operator_1 <= '0;
      alu_operator_2 <= '0;
      alu_opcode     <= '0;
      count          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            alu_operator_1 <= req_op1;
            alu_operator_2 <= req_op2;
            alu_opcode     <= req_opcode;
            tag_lat        <= req_tag;
            count          <= lat_load(req_opcode);
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            rsp_data  <= alu_answer;
            rsp_tag   <= tag_lat;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // rsp_ready on the capture edge is ignored: valid is always seen for a cycle.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
